// File: rtl/shift_add_sequencer.sv
// rtl/shift_add_sequencer.sv - Sequencer and accumulator for an MSB-first shift-add multiplier
module shift_add_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic                 mplierBit,
    output logic                 srLoad,
    output logic                 srShift,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        ADD   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] mcand;

    // Strobes are registered alongside the state they belong to, so each
    // branch sets the outputs for the state it is about to enter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            product <= '0;
            count   <= '0;
            mcand   <= '0;
            srLoad  <= 1'b0;
            srShift <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            srLoad  <= 1'b0;
            srShift <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= LOAD;
                        mcand  <= multiplicand;
                        srLoad <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                LOAD: begin
                    product <= '0;
                    count   <= '0;
                    state   <= SHIFT;
                    srShift <= 1'b1;
                    busy    <= 1'b1;
                end
                SHIFT: begin
                    state <= ADD;
                    busy  <= 1'b1;
                end
                ADD: begin
                    product <= {product[2*WIDTH-2:0], 1'b0}
                             + (mplierBit ? {{WIDTH{1'b0}}, mcand} : {(2*WIDTH){1'b0}});
                    count   <= count + CW'(1);
                    if (count == LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state   <= SHIFT;
                        srShift <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_sequencer.sv
// tb/tb_shift_add_sequencer.sv - Randomized self-checking bench with upstream shift register model
module tb_shift_add_sequencer;

    localparam int W   = 8;
    localparam int LAT = 2 * W + 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   multiplicand = '0;
    logic           mplierBit;
    logic           srLoad, srShift, busy, done;
    logic [2*W-1:0] product;

    logic [W-1:0]   mult_val = '0;
    logic [W-1:0]   sr = '0;
    logic           carry = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shift_add_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .multiplicand(multiplicand),
        .mplierBit(mplierBit), .srLoad(srLoad), .srShift(srShift),
        .busy(busy), .done(done), .product(product)
    );

    // Upstream left-shift register: carry presents the bit shifted out, MSB first.
    always @(posedge clk) begin
        if (srLoad) begin
            sr    <= mult_val;
            carry <= 1'b0;
        end else if (srShift) begin
            {carry, sr} <= {sr, 1'b0};
        end
    end
    assign mplierBit = carry;

    // Runs one operation starting from IDLE; returns done latency, product at
    // done, count of non-busy cycles before done, product one cycle later.
    task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                           output int lat, output logic [2*W-1:0] p,
                           output int busy_gaps, output logic [2*W-1:0] p_idle);
        mult_val     = a;
        multiplicand = b;
        start        = 1'b1;
        lat          = 0;
        busy_gaps    = 0;
        p            = '0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = k;
                p   = product;
                break;
            end
            if (!busy) busy_gaps++;
        end
        @(negedge clk);
        p_idle = product;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({srLoad, srShift, busy, done} !== 4'b0000 || product !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got strobes=%b product=%h, want 0000 / 0000",
                     {srLoad, srShift, busy, done}, product);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({srLoad, srShift, busy, done} !== 4'b0000) begin
            n_err++;
            $display("FAIL idle_outputs: got %b want 0000", {srLoad, srShift, busy, done});
        end
    endtask

    task automatic test_latency();
        int lat, gaps;
        logic [2*W-1:0] p, pi;
        do_mult(8'd11, 8'd13, lat, p, gaps, pi);
        n_cmp++;
        if (lat !== LAT) begin
            n_err++;
            $display("FAIL latency_11x13: got %0d want %0d", lat, LAT);
        end
        n_cmp++;
        if (p !== 16'h008F) begin
            n_err++;
            $display("FAIL product_11x13: got %h want 008f", p);
        end
        n_cmp++;
        if (gaps !== 0) begin
            n_err++;
            $display("FAIL busy_window: got %0d idle cycles want 0", gaps);
        end
        n_cmp++;
        if (pi !== 16'h008F || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL product_hold: got %h busy=%b done=%b want 008f 0 0", pi, busy, done);
        end
    endtask

    task automatic test_corners();
        logic [W-1:0] av[5] = '{8'd255, 8'd0,   8'd200, 8'd1, 8'd128};
        logic [W-1:0] bv[5] = '{8'd255, 8'd200, 8'd0,   8'd1, 8'd2};
        int lat, gaps;
        logic [2*W-1:0] p, pi, exp_p;
        for (int i = 0; i < 5; i++) begin
            exp_p = 16'(av[i]) * 16'(bv[i]);
            do_mult(av[i], bv[i], lat, p, gaps, pi);
            n_cmp++;
            if (p !== exp_p || lat !== LAT) begin
                n_err++;
                $display("FAIL corner_%0dx%0d: got %h lat %0d want %h lat %0d",
                         av[i], bv[i], p, lat, exp_p, LAT);
            end
        end
    endtask

    task automatic test_random();
        int lat, gaps;
        logic [W-1:0] a, b;
        logic [2*W-1:0] p, pi, exp_p;
        for (int i = 0; i < 20; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            exp_p = 16'(a) * 16'(b);
            do_mult(a, b, lat, p, gaps, pi);
            n_cmp++;
            if (p !== exp_p || lat !== LAT || gaps !== 0) begin
                n_err++;
                $display("FAIL random_%0dx%0d: got %h lat %0d gaps %0d want %h lat %0d gaps 0",
                         a, b, p, lat, gaps, exp_p, LAT);
            end
        end
    endtask

    task automatic test_strobes();
        int loads = 0, shifts = 0, both = 0;
        logic seen_done = 1'b0;
        mult_val     = 8'hA5;
        multiplicand = 8'h3C;
        start        = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (srLoad) loads++;
            if (srShift) shifts++;
            if (srLoad && srShift) both++;
            if (done) begin
                seen_done = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (loads !== 1 || shifts !== W || both !== 0 || !seen_done) begin
            n_err++;
            $display("FAIL strobe_counts: got load=%0d shift=%0d both=%0d done=%b want 1 %0d 0 1",
                     loads, shifts, both, seen_done, W);
        end
        n_cmp++;
        if (product !== 16'(8'hA5) * 16'(8'h3C)) begin
            n_err++;
            $display("FAIL strobe_product: got %h want %h", product, 16'(8'hA5) * 16'(8'h3C));
        end
        @(negedge clk);
    endtask

    task automatic test_held_inputs();
        int done_cnt = 0, busy_after = 0, lat = 0;
        logic [2*W-1:0] p_done = '0;
        mult_val     = 8'd11;
        multiplicand = 8'd13;
        start        = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 5) begin
                start        = 1'b1;
                multiplicand = W'($urandom);
                mult_val     = W'($urandom);
            end
            if (done) begin
                done_cnt++;
                lat    = k;
                p_done = product;
                start        = 1'b1;
                multiplicand = 8'd99;
                break;
            end
        end
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 25; k++) begin
            if (busy) busy_after++;
            if (done) done_cnt++;
            @(negedge clk);
        end
        n_cmp++;
        if (p_done !== 16'h008F || lat !== LAT) begin
            n_err++;
            $display("FAIL held_result: got %h lat %0d want 008f lat %0d", p_done, lat, LAT);
        end
        n_cmp++;
        if (done_cnt !== 1 || busy_after !== 0) begin
            n_err++;
            $display("FAIL held_no_requeue: got done=%0d busy_cycles=%0d want 1 0", done_cnt, busy_after);
        end
        n_cmp++;
        if (product !== 16'h008F) begin
            n_err++;
            $display("FAIL held_product_idle: got %h want 008f", product);
        end
    endtask

    task automatic test_mid_reset();
        int lat, gaps;
        logic [2*W-1:0] p, pi;
        mult_val     = 8'd11;
        multiplicand = 8'd13;
        start        = 1'b1;
        // ADDs fall on cycles t+3, t+5, t+7, t+9; reset during the fourth.
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
            n_err++;
            $display("FAIL mid_reset: got busy=%b done=%b product=%h want 0 0 0000", busy, done, product);
        end
        rst = 1'b0;
        do_mult(8'd7, 8'd9, lat, p, gaps, pi);
        n_cmp++;
        if (p !== 16'd63 || lat !== LAT) begin
            n_err++;
            $display("FAIL after_reset_7x9: got %h lat %0d want 003f lat %0d", p, lat, LAT);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] av[4], bv[4];
        logic [2*W-1:0] exp_p;
        int idx = 0, last = 0;
        for (int i = 0; i < 4; i++) begin
            av[i] = W'($urandom);
            bv[i] = W'($urandom);
        end
        mult_val     = av[0];
        multiplicand = bv[0];
        start        = 1'b1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (done) begin
                exp_p = 16'(av[idx]) * 16'(bv[idx]);
                n_cmp++;
                if (product !== exp_p) begin
                    n_err++;
                    $display("FAIL b2b_product_%0d: got %h want %h", idx, product, exp_p);
                end
                n_cmp++;
                if (cyc - last !== (idx == 0 ? LAT : LAT + 1)) begin
                    n_err++;
                    $display("FAIL b2b_spacing_%0d: got %0d want %0d", idx, cyc - last,
                             (idx == 0 ? LAT : LAT + 1));
                end
                last = cyc;
                idx++;
                if (idx == 4) break;
                mult_val     = av[idx];
                multiplicand = bv[idx];
            end
        end
        start = 1'b0;
        n_cmp++;
        if (idx !== 4) begin
            n_err++;
            $display("FAIL b2b_count: got %0d operations want 4", idx);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_corners();
        test_random();
        test_strobes();
        test_held_inputs();
        test_mid_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
